lvdc_uplink_sequencer: RTL and testbench
========================================

# lvdc_uplink_sequencer

Ground-side sequencer that drives the LVDC serial data-input port (DATAV, DIN), its interrupt line (INTCV) and its halt line (HALTV). It arbitrates between two word sources, the checkout console (port 0) and the uplink decoder (port 1), and serialises one word at a time MSB-first. After each word it can optionally pulse an interrupt. It sits between the ground-support logic and the `lvdc` instance in the simulation top.

## Interface
- WORD_W, 26: bits per transferred word (data plus parity, no syllable split).
- BIT_DIV, 4: clocks each serial bit is held on DIN; ≥2.
- INT_W, 3: INTCV pulse width in clocks; ≥1.
- GAP_CYC, 2: idle clocks enforced between transfers; ≥1.

- CLK  in  1  sequencer clock.
- RSTN  in  1  asynchronous, active-low reset.
- REQ0, REQ1  in  1 each  transfer request; held high until ACK.
- WORD0, WORD1  in  WORD_W each  word to send; sampled at grant.
- INT0, INT1  in  1 each  pulse INTCV after this word; sampled at grant.
- ACK0, ACK1  out  1 each  one-clock completion pulse to the granted requester.
- ERR  out  1  high together with ACK when the transfer was aborted.
- ABORT  in  1  terminate the current transfer.
- HALT_REQ  in  1  request LVDC halt.
- DATAV  out  1  word-valid envelope.
- DIN  out  1  serial data bit.
- INTCV  out  1  interrupt pulse.
- HALTV  out  1  halt level.
- BUSY  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, SHIFT, INTR, GAP.
- Reset: all outputs are 0, state is IDLE, and the round-robin pointer favours port 0.
- **IDLE**
  - If HALTV=0 and a REQ is high: grant one requester, latch its WORD and INT flag, and go to SHIFT.
  - Arbitration is round-robin: when both requests are high, the port that did not win last is granted. The pointer updates on every grant.
  - HALTV follows HALT_REQ, and changes only while in IDLE.
  - While HALTV=1, no grants are made.
- **SHIFT**
  - DATAV=1 for the whole state.
  - DIN carries the latched word, bit WORD_W-1 first. Each bit is held for BIT_DIV clocks.
  - A bit counter runs WORD_W-1 down to 0; a divider runs BIT_DIV-1 down to 0.
  - After the last clock of bit 0:
    - DATAV and DIN fall to 0.
    - The granted ACKx pulses.
    - Next state is INTR if the latched INT flag is 1, otherwise GAP.
- **INTR**: INTCV=1 for INT_W clocks, then GAP.
- **GAP**: all outputs are idle for GAP_CYC clocks, then IDLE.
- **ABORT**
  - Sampled high in SHIFT: on the next clock DATAV=DIN=0, ACKx=1 and ERR=1, and the block goes to GAP. No interrupt is issued, even if INT was set.
  - Ignored in all other states.
- **HALT_REQ mid-transfer**: the transfer completes normally. HALTV rises in the first IDLE cycle, and the pending request is not granted.
- **Request withdrawal**: a REQ dropped before ACK does not cancel the transfer, and ACK still pulses. WORD/INT changes after the grant are ignored.

## Timing
- Cycle 0 is the IDLE cycle in which a grant occurs.
- DATAV is high in cycles 1 .. WORD_W·BIT_DIV (defaults: 1..104).
- Bit k (k = WORD_W-1 down to 0) occupies cycles (WORD_W-1-k)·BIT_DIV+1 .. (WORD_W-k)·BIT_DIV.
- ACK, and the first INTCV cycle if INT is set, fall in cycle WORD_W·BIT_DIV+1 (default 105).
- With INT: INTCV occupies 105..107, GAP 108..109, IDLE at 110, next DATAV at 111.
- Without INT: GAP 105..106, IDLE at 107, next DATAV at 108.
- Outputs are registered, with no combinational path from inputs to outputs. ACKx and ERR are single-cycle pulses.
- Reset asserted mid-operation: all outputs drop asynchronously and the block restarts from IDLE; no ACK is issued.

## Test plan
- **Single word**: REQ0 with WORD0=26'h2AAAAAA, INT0=0.
  - DATAV high cycles 1–104.
  - DIN=1 in cycles 1–4, 0 in cycles 5–8, alternating thereafter.
  - ACK0 pulses in cycle 105, INTCV stays 0, BUSY falls at cycle 107.
- **Interrupt**: REQ1 with WORD1=26'h3FFFFFF, INT1=1.
  - DIN=1 for all 104 cycles.
  - INTCV is high in cycles 105–107.
  - ACK1 pulses at 105.
- **Round-robin**: REQ0 and REQ1 are held high continuously.
  - Grant order is 0,1,0,1.
  - Back-to-back DATAV envelopes start 107 cycles apart (no INT).
- **Abort**: ABORT pulsed in cycle 40.
  - DATAV=0 from cycle 41.
  - ACK0 and ERR are high at 41, INTCV stays 0 even with INT0=1.
  - IDLE at 43.
- **Halt**: HALT_REQ raised at cycle 50 of a transfer while REQ1 is pending.
  - The transfer completes.
  - HALTV rises at 107, and REQ1 is not granted.
  - HALT_REQ low → HALTV=0 and the grant occur in the same IDLE cycle.
- **Reset mid-shift**: RSTN pulled low at cycle 60.
  - DATAV, DIN, ACK0 and BUSY are all 0 immediately.
  - After release, REQ0 is re-granted and the full word is sent.

Source files
------------

// File: rtl/lvdc_uplink_sequencer.sv
// Ground-side LVDC data-input sequencer: round-robin arbitration of two word sources,
// MSB-first serialisation on DIN/DATAV, optional INTCV pulse and HALTV level control.
module lvdc_uplink_sequencer #(
  parameter int unsigned WORD_W  = 26,
  parameter int unsigned BIT_DIV = 4,
  parameter int unsigned INT_W   = 3,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [WORD_W-1:0] word0,
  input  logic [WORD_W-1:0] word1,
  input  logic              int0,
  input  logic              int1,
  output logic              ack0,
  output logic              ack1,
  output logic              err,
  input  logic              abort,
  input  logic              halt_req,
  output logic              datav,
  output logic              din,
  output logic              intcv,
  output logic              haltv,
  output logic              busy
);

  localparam int unsigned CntMax0 = (BIT_DIV > INT_W) ? BIT_DIV : INT_W;
  localparam int unsigned CntMax  = (CntMax0 > GAP_CYC) ? CntMax0 : GAP_CYC;
  localparam int unsigned CntW    = $clog2(CntMax);
  localparam int unsigned BitW    = $clog2(WORD_W);

  localparam logic [CntW-1:0] DivLast = CntW'(BIT_DIV - 1);
  localparam logic [CntW-1:0] IntLast = CntW'(INT_W - 1);
  localparam logic [CntW-1:0] GapLast = CntW'(GAP_CYC - 1);
  localparam logic [BitW-1:0] BitTop  = BitW'(WORD_W - 1);

  typedef enum logic [1:0] {StIdle, StShift, StIntr, StGap} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              intf_q, intf_d;
  logic              gnt_q, gnt_d;
  logic              prio_q, prio_d;
  logic              done, aborted;

  logic datav_q, datav_d;
  logic din_q, din_d;
  logic intcv_q, intcv_d;
  logic haltv_q, haltv_d;
  logic busy_q, busy_d;
  logic ack0_q, ack0_d;
  logic ack1_q, ack1_d;
  logic err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      intf_q  <= 1'b0;
      gnt_q   <= 1'b0;
      prio_q  <= 1'b0;
      datav_q <= 1'b0;
      din_q   <= 1'b0;
      intcv_q <= 1'b0;
      haltv_q <= 1'b0;
      busy_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      intf_q  <= intf_d;
      gnt_q   <= gnt_d;
      prio_q  <= prio_d;
      datav_q <= datav_d;
      din_q   <= din_d;
      intcv_q <= intcv_d;
      haltv_q <= haltv_d;
      busy_q  <= busy_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    intf_d  = intf_q;
    gnt_d   = gnt_q;
    prio_d  = prio_q;
    done    = 1'b0;
    aborted = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!haltv_q && (req0 || req1)) begin
          // prio_q names the port that did not win last time
          gnt_d   = (req0 && req1) ? prio_q : req1;
          prio_d  = ~gnt_d;
          shreg_d = gnt_d ? word1 : word0;
          intf_d  = gnt_d ? int1 : int0;
          bit_d   = BitTop;
          cnt_d   = DivLast;
          state_d = StShift;
        end
      end
      StShift: begin
        if (abort) begin
          done    = 1'b1;
          aborted = 1'b1;
          cnt_d   = GapLast;
          state_d = StGap;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bit_q != '0) begin
          bit_d   = bit_q - 1'b1;
          cnt_d   = DivLast;
          shreg_d = {shreg_q[WORD_W-2:0], 1'b0};
        end else begin
          done = 1'b1;
          if (intf_q) begin
            cnt_d   = IntLast;
            state_d = StIntr;
          end else begin
            cnt_d   = GapLast;
            state_d = StGap;
          end
        end
      end
      StIntr: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          cnt_d   = GapLast;
          state_d = StGap;
        end
      end
      StGap: begin
        if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else             state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are computed from the next state and registered, so nothing on the pins is
  // combinationally derived from inputs.
  always_comb begin
    datav_d = (state_d == StShift);
    din_d   = datav_d & shreg_d[WORD_W-1];
    intcv_d = (state_d == StIntr);
    busy_d  = (state_d != StIdle);
    ack0_d  = done & ~gnt_q;
    ack1_d  = done & gnt_q;
    err_d   = aborted;
    haltv_d = (state_d == StIdle) ? halt_req : haltv_q;
  end

  assign datav = datav_q;
  assign din   = din_q;
  assign intcv = intcv_q;
  assign haltv = haltv_q;
  assign busy  = busy_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign err   = err_q;

endmodule

// File: tb/tb_lvdc_uplink_sequencer.sv
// Scoreboard bench for lvdc_uplink_sequencer: stimulus pushes expected transfers, a negedge
// monitor reconstructs each serial word and checks it when ACK appears.
module tb_lvdc_uplink_sequencer;

  localparam int unsigned WORD_W  = 26;
  localparam int unsigned BIT_DIV = 4;
  localparam int unsigned INT_W   = 3;
  localparam int unsigned GAP_CYC = 2;
  localparam int unsigned NBITS   = WORD_W * BIT_DIV;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, int0, int1, abort, halt_req;
  logic [WORD_W-1:0] word0, word1;
  logic              ack0, ack1, err, datav, din, intcv, haltv, busy;

  lvdc_uplink_sequencer #(
    .WORD_W (WORD_W),
    .BIT_DIV(BIT_DIV),
    .INT_W  (INT_W),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .req1    (req1),
    .word0   (word0),
    .word1   (word1),
    .int0    (int0),
    .int1    (int1),
    .ack0    (ack0),
    .ack1    (ack1),
    .err     (err),
    .abort   (abort),
    .halt_req(halt_req),
    .datav   (datav),
    .din     (din),
    .intcv   (intcv),
    .haltv   (haltv),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              port;
    logic              err;
    logic [WORD_W-1:0] word;
    int                dv;
    logic              intr;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  task automatic push(input logic p, input logic e, input logic [WORD_W-1:0] w, input int dv,
                      input logic i);
    exp_t x;
    x.port = p; x.err = e; x.word = w; x.dv = dv; x.intr = i;
    sb.push_back(x);
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  logic dv_bits[NBITS];
  int   dv_cnt  = 0;
  int   int_win = 0;
  int   int_run = 0;
  logic int_exp = 1'b0;

  initial begin
    exp_t e;
    logic ok;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        dv_cnt  = 0;
        int_win = 0;
      end else begin
        if (datav === 1'b1) begin
          if (dv_cnt < int'(NBITS)) dv_bits[dv_cnt] = din;
          dv_cnt++;
        end
        if (ack0 === 1'b1 || ack1 === 1'b1) begin
          if (sb.size() == 0) begin
            chk("ack_unexpected", 32'({ack1, ack0}), 0);
          end else begin
            e = sb.pop_front();
            chk("ack_port", 32'({ack1, ack0}), e.port ? 2 : 1);
            chk("ack_err", 32'(err), 32'(e.err));
            chk("datav_len", dv_cnt, e.dv);
            ok = 1'b1;
            for (int c = 0; c < dv_cnt && c < int'(NBITS); c++)
              if (dv_bits[c] !== e.word[WORD_W-1-c/BIT_DIV]) ok = 1'b0;
            chk("din_stream", 32'(ok), 1);
            int_exp = e.intr;
            int_win = INT_W + GAP_CYC;
            int_run = 0;
          end
          dv_cnt = 0;
        end
        if (int_win > 0) begin
          if (intcv === 1'b1) int_run++;
          int_win--;
          if (int_win == 0) chk("intcv_len", int_run, int_exp ? INT_W : 0);
        end else if (intcv !== 1'b0) begin
          chk("intcv_stray", 32'(intcv), 0);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ack(input logic port, input int exp_cyc, input string name);
    while (!((port ? ack1 : ack0) === 1'b1) && cyc < exp_cyc + 40) tick();
    chk(name, cyc, exp_cyc);
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic idle_wait();
    int k = 0;
    while (busy !== 1'b0 && k < 300) begin
      tick();
      k++;
    end
    chk("idle_wait", 32'(busy), 0);
  endtask

  initial begin
    int rises[4];
    int nr, acks;
    logic prev_dv;

    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; int0 = 1'b0; int1 = 1'b0;
    abort = 1'b0; halt_req = 1'b0; word0 = '0; word1 = '0;
    tick(); tick(); tick();
    chk("reset_outs", 32'({datav, din, ack0, ack1, err, intcv, haltv, busy}), 0);
    rst_n = 1'b1;
    tick(); tick();

    // Single word, alternating nibbles on DIN
    cyc = 0;
    req0 = 1'b1; word0 = 26'h2AAAAAA; int0 = 1'b0;
    push(1'b0, 1'b0, 26'h2AAAAAA, NBITS, 1'b0);
    tick();
    chk("t1_datav_c1", 32'({datav, din}), 3);
    while (cyc < 5) tick();
    chk("t1_din_c5", 32'({datav, din}), 2);
    wait_ack(1'b0, 105, "t1_ack_cyc");
    chk("t1_intcv_105", 32'(intcv), 0);
    tick();
    chk("t1_busy_106", 32'(busy), 1);
    tick();
    chk("t1_busy_107", 32'(busy), 0);

    // Interrupt from port 1
    cyc = 0;
    req1 = 1'b1; word1 = 26'h3FFFFFF; int1 = 1'b1;
    push(1'b1, 1'b0, 26'h3FFFFFF, NBITS, 1'b1);
    wait_ack(1'b1, 105, "t2_ack_cyc");
    chk("t2_intcv_105", 32'(intcv), 1);
    tick(); tick();
    chk("t2_intcv_107", 32'(intcv), 1);
    tick();
    chk("t2_intcv_108", 32'(intcv), 0);
    tick(); tick();
    chk("t2_busy_110", 32'(busy), 0);
    int1 = 1'b0;

    // Round-robin with both requests held
    cyc = 0;
    word0 = 26'h0F0F0F0; word1 = 26'h1C3A5E7;
    req0 = 1'b1; req1 = 1'b1;
    push(1'b0, 1'b0, 26'h0F0F0F0, NBITS, 1'b0);
    push(1'b1, 1'b0, 26'h1C3A5E7, NBITS, 1'b0);
    push(1'b0, 1'b0, 26'h0F0F0F0, NBITS, 1'b0);
    push(1'b1, 1'b0, 26'h1C3A5E7, NBITS, 1'b0);
    nr = 0; acks = 0; prev_dv = 1'b0;
    while (acks < 4 && cyc < 600) begin
      tick();
      if (datav === 1'b1 && prev_dv === 1'b0 && nr < 4) begin
        rises[nr] = cyc;
        nr++;
      end
      prev_dv = datav;
      if (ack0 === 1'b1 || ack1 === 1'b1) acks++;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t3_acks", acks, 4);
    chk("t3_nrises", nr, 4);
    chk("t3_rise0", rises[0], 1);
    for (int i = 1; i < 4; i++) chk("t3_spacing", rises[i] - rises[i-1], 107);
    idle_wait();

    // Abort at cycle 40 suppresses the interrupt
    cyc = 0;
    req0 = 1'b1; word0 = 26'h155AA33; int0 = 1'b1;
    push(1'b0, 1'b1, 26'h155AA33, 40, 1'b0);
    while (cyc < 40) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t4_c41", 32'({datav, ack0, err, intcv}), 32'b0110);
    req0 = 1'b0; int0 = 1'b0;
    tick();
    chk("t4_busy_42", 32'(busy), 1);
    tick();
    chk("t4_busy_43", 32'(busy), 0);

    // Halt requested mid-transfer with port 1 pending
    cyc = 0;
    req0 = 1'b1; word0 = 26'h0ABCDEF;
    push(1'b0, 1'b0, 26'h0ABCDEF, NBITS, 1'b0);
    tick();
    req1 = 1'b1; word1 = 26'h3000001;
    push(1'b1, 1'b0, 26'h3000001, NBITS, 1'b0);
    while (cyc < 50) tick();
    halt_req = 1'b1;
    wait_ack(1'b0, 105, "t5_ack0_cyc");
    tick(); tick();
    chk("t5_c107", 32'({haltv, busy}), 2);
    while (cyc < 115) tick();
    chk("t5_c115_held", 32'({haltv, busy, datav}), 4);
    halt_req = 1'b0;
    tick();
    chk("t5_c116", 32'({haltv, busy, datav}), 0);
    tick();
    chk("t5_c117", 32'(datav), 1);
    wait_ack(1'b1, 221, "t5_ack1_cyc");
    idle_wait();

    // Reset in the middle of a shift
    cyc = 0;
    req0 = 1'b1; word0 = 26'h3FFFFFF;
    while (cyc < 60) tick();
    chk("t6_pre", 32'({datav, din}), 3);
    rst_n = 1'b0;
    #1;
    chk("t6_rst", 32'({datav, din, ack0, busy}), 0);
    word0 = 26'h1234567;
    tick(); tick();
    rst_n = 1'b1;
    cyc = 0;
    push(1'b0, 1'b0, 26'h1234567, NBITS, 1'b0);
    wait_ack(1'b0, 105, "t6_ack_cyc");
    idle_wait();
    tick(); tick(); tick(); tick(); tick();

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
